// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped store buffer.
// Holds the default I/O window base, the register offsets within the
// window and the STATUS bit positions. The decoder and the bench both
// import this package.
package io_pkg;

    // Default base of the 256-byte I/O window.
    localparam logic [15:0] IO_BASE = 16'hFF00;

    // Register offsets from the window base.
    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h02;
    localparam logic [7:0] OFF_CLEAR  = 8'h04;

    // STATUS register bit positions.
    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVERFLOW  = 2;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO holding the queued I/O store words.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset of pointers and count
//   push   - write wdata at the tail (ignored when full without a pop)
//   pop    - advance the head (ignored when empty)
//   wdata  - data to enqueue
//   rdata  - head entry, straight from storage (no path from pop)
//   full   - count == DEPTH
//   empty  - count == 0
//   count  - occupancy, 0..DEPTH
module io_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        pop_ok  = pop & ~empty;
        // A full FIFO can still accept when the head leaves at the same edge.
        push_ok = push & (~full | pop_ok);

        // DEPTH is a power of two, so the pointers wrap naturally.
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

        rdata = mem[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/io_store_buffer.sv
// Memory-mapped I/O store buffer.
// CPU stores into the I/O window are decoded here: DATA writes enqueue the
// store word into an output FIFO drained by a valid/ready consumer, CLEAR
// writes clear the sticky overflow flag, and STATUS reads return occupancy
// and overflow state.
// Ports:
//   CLK, RESET  - clock and synchronous active-high reset
//   wmem        - store enable
//   addr        - store/load address
//   wdata       - store data
//   io_sel      - addr lies inside the I/O window (combinational)
//   rd_data     - combinational register read value
//   out_valid   - head entry valid (registered state)
//   out_ready   - consumer accepts the head entry
//   out_data    - head entry data
//   full, empty - FIFO occupancy flags
//   overflow    - sticky: a DATA store was dropped while full
//   count       - FIFO occupancy, 0..DEPTH, for observability
module io_store_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [15:0] IO_BASE = io_pkg::IO_BASE
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   wmem,
    input  logic [15:0]            addr,
    input  logic [15:0]            wdata,
    output logic                   io_sel,
    output logic [15:0]            rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);

    import io_pkg::*;

    logic [15:0] offset;
    logic [7:0]  reg_off;
    logic        data_wr;
    logic        clear_wr;
    logic        pop;
    logic        drop;
    logic [15:0] status;
    logic        overflow_q, overflow_d;

    always_comb begin
        // Window test by subtraction, so IO_BASE need not be 256-aligned.
        offset   = addr - IO_BASE;
        io_sel   = (offset[15:8] == 8'h00);
        reg_off  = offset[7:0];

        data_wr  = wmem & io_sel & (reg_off == OFF_DATA);
        clear_wr = wmem & io_sel & (reg_off == OFF_CLEAR);
        pop      = out_ready & ~empty;
        drop     = data_wr & full & ~pop;

        overflow_d = overflow_q;
        if (clear_wr) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end

        status                 = '0;
        status[STAT_NOT_EMPTY] = ~empty;
        status[STAT_FULL]      = full;
        status[STAT_OVERFLOW]  = overflow_q;

        rd_data = '0;
        if (io_sel && (reg_off == OFF_STATUS)) begin
            rd_data = status;
        end

        out_valid = ~empty;
        overflow  = overflow_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    // The FIFO itself refuses a push when full without a pop.
    io_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (CLK),
        .reset (RESET),
        .push  (data_wr),
        .pop   (pop),
        .wdata (wdata),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule
